// File: rtl/mem_io_responder_if.sv
// CPU byte-bus, UART byte streams and status flags shared by the memory/IO responder and its bus master.
interface mem_io_responder_if;
   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        halted;
   logic        tx_overflow;
   logic        rx_overflow;

   modport master (
      output cpu_a, cpu_dout, cpu_wr, tx_ready, rx_data, rx_valid,
      input  cpu_din, io_buffer_full, tx_data, tx_valid, halted, tx_overflow, rx_overflow
   );

   modport slave (
      input  cpu_a, cpu_dout, cpu_wr, tx_ready, rx_data, rx_valid,
      output cpu_din, io_buffer_full, tx_data, tx_valid, halted, tx_overflow, rx_overflow
   );
endinterface

// File: rtl/mem_io_responder.sv
// Bus target: byte RAM, UART TX/RX queues, cycle counter with snapshot and halt flag.
// Read data is registered; queue status outputs are combinational from registered queue state.
module mem_io_responder #(
   parameter int unsigned ADDR_WIDTH  = 17,
   parameter int unsigned TXQ_DEPTH   = 16,
   parameter int unsigned RXQ_DEPTH   = 16,
   parameter int unsigned FULL_MARGIN = 4
) (
   input logic               clk_in,
   input logic               rst_in,
   mem_io_responder_if.slave bus
);
   localparam int unsigned TXQ_AW    = $clog2(TXQ_DEPTH);
   localparam int unsigned RXQ_AW    = $clog2(RXQ_DEPTH);
   localparam int unsigned TXQ_CW    = TXQ_AW + 1;
   localparam int unsigned RXQ_CW    = RXQ_AW + 1;
   localparam int unsigned RAM_BYTES = 2 ** ADDR_WIDTH;

   localparam logic [17:0] IO_DATA  = 18'h30000;
   localparam logic [17:0] IO_CNT   = 18'h30004;
   localparam logic [17:0] IO_SNAP1 = 18'h30005;
   localparam logic [17:0] IO_SNAP2 = 18'h30006;
   localparam logic [17:0] IO_SNAP3 = 18'h30007;

   // Address decode
   logic [17:0]           w_a;
   logic [ADDR_WIDTH-1:0] w_ram_idx;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_is_ram;
   logic                  w_io_data;
   logic                  w_io_cnt;
   logic                  w_unused;

   assign w_a       = bus.cpu_a[17:0];
   assign w_ram_idx = bus.cpu_a[ADDR_WIDTH-1:0];
   assign w_wr      = bus.cpu_wr;
   assign w_rd      = !bus.cpu_wr;
   assign w_is_ram  = !w_a[17];
   assign w_io_data = (w_a == IO_DATA);
   assign w_io_cnt  = (w_a == IO_CNT);
   assign w_unused  = ^bus.cpu_a[31:18];

   // Byte RAM, contents not reset; writes dropped while reset is held
   logic [7:0] r_mem [RAM_BYTES];

   always_ff @(posedge clk_in) begin
      if (rst_in && w_wr && w_is_ram) begin
         r_mem[w_ram_idx] <= bus.cpu_dout;
      end
   end

   // TX queue state
   logic [7:0]        r_txq [TXQ_DEPTH];
   logic [TXQ_AW-1:0] r_tx_wp;
   logic [TXQ_AW-1:0] r_tx_rp;
   logic [TXQ_CW-1:0] r_tx_cnt;
   logic              r_tx_ovf;
   logic              w_tx_full;
   logic              w_tx_pop;
   logic              w_tx_push_req;
   logic              w_tx_push;
   logic [7:0]        w_tx_push_byte;

   assign w_tx_full      = (r_tx_cnt == TXQ_CW'(TXQ_DEPTH));
   assign w_tx_pop       = (r_tx_cnt != '0) && bus.tx_ready;
   assign w_tx_push_req  = w_wr && ((w_io_data && (bus.cpu_dout != 8'h00)) || w_io_cnt);
   assign w_tx_push_byte = w_io_cnt ? 8'h00 : bus.cpu_dout;
   // A simultaneous pop frees the slot, so a push into a full queue is still taken
   assign w_tx_push      = w_tx_push_req && (!w_tx_full || w_tx_pop);

   always_ff @(posedge clk_in) begin
      if (w_tx_push) begin
         r_txq[r_tx_wp] <= w_tx_push_byte;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
         r_tx_ovf <= 1'b0;
      end else begin
         if (w_tx_push) begin
            r_tx_wp <= r_tx_wp + TXQ_AW'(1);
         end
         if (w_tx_pop) begin
            r_tx_rp <= r_tx_rp + TXQ_AW'(1);
         end
         if (w_tx_push && !w_tx_pop) begin
            r_tx_cnt <= r_tx_cnt + TXQ_CW'(1);
         end else if (!w_tx_push && w_tx_pop) begin
            r_tx_cnt <= r_tx_cnt - TXQ_CW'(1);
         end
         if (w_tx_push_req && !w_tx_push) begin
            r_tx_ovf <= 1'b1;
         end
      end
   end

   // RX queue state
   logic [7:0]        r_rxq [RXQ_DEPTH];
   logic [RXQ_AW-1:0] r_rx_wp;
   logic [RXQ_AW-1:0] r_rx_rp;
   logic [RXQ_CW-1:0] r_rx_cnt;
   logic              r_rx_ovf;
   logic              w_rx_full;
   logic              w_rx_pop;
   logic              w_rx_push;
   logic [7:0]        w_rx_head;

   assign w_rx_full = (r_rx_cnt == RXQ_CW'(RXQ_DEPTH));
   // An empty queue is never popped, so a same-cycle push on empty is retained
   assign w_rx_pop  = w_rd && w_io_data && (r_rx_cnt != '0);
   assign w_rx_push = bus.rx_valid && (!w_rx_full || w_rx_pop);
   assign w_rx_head = (r_rx_cnt != '0) ? r_rxq[r_rx_rp] : 8'h00;

   always_ff @(posedge clk_in) begin
      if (w_rx_push) begin
         r_rxq[r_rx_wp] <= bus.rx_data;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
         r_rx_ovf <= 1'b0;
      end else begin
         if (w_rx_push) begin
            r_rx_wp <= r_rx_wp + RXQ_AW'(1);
         end
         if (w_rx_pop) begin
            r_rx_rp <= r_rx_rp + RXQ_AW'(1);
         end
         if (w_rx_push && !w_rx_pop) begin
            r_rx_cnt <= r_rx_cnt + RXQ_CW'(1);
         end else if (!w_rx_push && w_rx_pop) begin
            r_rx_cnt <= r_rx_cnt - RXQ_CW'(1);
         end
         if (bus.rx_valid && !w_rx_push) begin
            r_rx_ovf <= 1'b1;
         end
      end
   end

   // Read data select
   logic [31:0] r_count;
   logic [23:0] r_snap;
   logic [7:0]  w_rd_data;

   always_comb begin
      w_rd_data = 8'h00;
      if (w_is_ram) begin
         w_rd_data = r_mem[w_ram_idx];
      end else begin
         case (w_a)
            IO_DATA:  w_rd_data = w_rx_head;
            IO_CNT:   w_rd_data = r_count[7:0];
            IO_SNAP1: w_rd_data = r_snap[7:0];
            IO_SNAP2: w_rd_data = r_snap[15:8];
            IO_SNAP3: w_rd_data = r_snap[23:16];
            default:  w_rd_data = 8'h00;
         endcase
      end
   end

   // Read register, cycle counter, snapshot and halt flag
   logic [7:0] r_cpu_din;
   logic       r_halted;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_cpu_din <= 8'h00;
         r_count   <= '0;
         r_snap    <= '0;
         r_halted  <= 1'b0;
      end else begin
         r_count <= r_count + 32'd1;
         if (w_rd) begin
            r_cpu_din <= w_rd_data;
         end
         if (w_rd && w_io_cnt) begin
            r_snap <= r_count[31:8];
         end
         if (w_wr && w_io_cnt) begin
            r_halted <= 1'b1;
         end
      end
   end

   assign bus.cpu_din        = r_cpu_din;
   assign bus.io_buffer_full = (r_tx_cnt >= TXQ_CW'(TXQ_DEPTH - FULL_MARGIN));
   assign bus.tx_valid       = (r_tx_cnt != '0);
   assign bus.tx_data        = (r_tx_cnt != '0) ? r_txq[r_tx_rp] : 8'h00;
   assign bus.halted         = r_halted;
   assign bus.tx_overflow    = r_tx_ovf;
   assign bus.rx_overflow    = r_rx_ovf;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized plus directed bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;
   localparam int TXQ_DEPTH   = 16;
   localparam int RXQ_DEPTH   = 16;
   localparam int FULL_MARGIN = 4;

   logic clk;
   logic rst_n;

   mem_io_responder_if bus ();

   mem_io_responder #(
      .ADDR_WIDTH  (17),
      .TXQ_DEPTH   (TXQ_DEPTH),
      .RXQ_DEPTH   (RXQ_DEPTH),
      .FULL_MARGIN (FULL_MARGIN)
   ) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   // Reference model state
   logic [7:0]  ram_m [int];
   logic [7:0]  txq [$];
   logic [7:0]  rxq [$];
   logic [31:0] m_cnt;
   logic [23:0] m_snap;
   logic [7:0]  m_din;
   bit          m_din_known;
   bit          m_halt;
   bit          m_txo;
   bit          m_rxo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      m_cnt       = '0;
      m_snap      = '0;
      m_din       = 8'h00;
      m_din_known = 1'b1;
      m_halt      = 1'b0;
      m_txo       = 1'b0;
      m_rxo       = 1'b0;
   endtask

   // One bus cycle: drive, predict, clock, compare every observable output
   task automatic do_cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                           input logic rdy, input logic rv, input logic [7:0] rd);
      logic [17:0] ia;
      bit          tx_pop;
      bit          rx_pop;
      bit          tx_req;
      bit          tx_was_full;
      bit          rx_was_full;
      logic [7:0]  tx_byte;
      bus.cpu_a    = a;
      bus.cpu_wr   = wr;
      bus.cpu_dout = d;
      bus.tx_ready = rdy;
      bus.rx_valid = rv;
      bus.rx_data  = rd;
      ia          = a[17:0];
      tx_was_full = (txq.size() == TXQ_DEPTH);
      rx_was_full = (rxq.size() == RXQ_DEPTH);
      tx_pop      = rdy && (txq.size() > 0);
      rx_pop      = !wr && (ia == 18'h30000) && (rxq.size() > 0);
      tx_req      = wr && (((ia == 18'h30000) && (d != 8'h00)) || (ia == 18'h30004));
      tx_byte     = (ia == 18'h30004) ? 8'h00 : d;
      if (!wr) begin
         m_din_known = 1'b1;
         if (!ia[17]) begin
            if (ram_m.exists(int'(ia[16:0]))) m_din = ram_m[int'(ia[16:0])];
            else m_din_known = 1'b0;
         end else if (ia == 18'h30000) m_din = rx_pop ? rxq[0] : 8'h00;
         else if (ia == 18'h30004) begin
            m_din  = m_cnt[7:0];
            m_snap = m_cnt[31:8];
         end
         else if (ia == 18'h30005) m_din = m_snap[7:0];
         else if (ia == 18'h30006) m_din = m_snap[15:8];
         else if (ia == 18'h30007) m_din = m_snap[23:16];
         else m_din = 8'h00;
      end else begin
         if (!ia[17]) ram_m[int'(ia[16:0])] = d;
         if (ia == 18'h30004) m_halt = 1'b1;
      end
      if (tx_pop) void'(txq.pop_front());
      if (tx_req) begin
         if (!tx_was_full || tx_pop) txq.push_back(tx_byte);
         else m_txo = 1'b1;
      end
      if (rx_pop) void'(rxq.pop_front());
      if (rv) begin
         if (!rx_was_full || rx_pop) rxq.push_back(rd);
         else m_rxo = 1'b1;
      end
      m_cnt = m_cnt + 32'd1;
      @(posedge clk);
      #1;
      if (m_din_known) chk("cpu_din", 32'(bus.cpu_din), 32'(m_din));
      chk("tx_valid", 32'(bus.tx_valid), 32'(txq.size() != 0));
      chk("tx_data", 32'(bus.tx_data), (txq.size() != 0) ? 32'(txq[0]) : 32'h0);
      chk("io_buffer_full", 32'(bus.io_buffer_full), 32'(txq.size() >= TXQ_DEPTH - FULL_MARGIN));
      chk("halted", 32'(bus.halted), 32'(m_halt));
      chk("tx_overflow", 32'(bus.tx_overflow), 32'(m_txo));
      chk("rx_overflow", 32'(bus.rx_overflow), 32'(m_rxo));
   endtask

   task automatic rd_cycle(input logic [31:0] a, input logic rdy);
      do_cycle(a, 1'b0, 8'h00, rdy, 1'b0, 8'h00);
   endtask

   task automatic wr_cycle(input logic [31:0] a, input logic [7:0] d, input logic rdy);
      do_cycle(a, 1'b1, d, rdy, 1'b0, 8'h00);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_din"}, 32'(bus.cpu_din), 32'h0);
      chk({tag, "_full"}, 32'(bus.io_buffer_full), 32'h0);
      chk({tag, "_txv"}, 32'(bus.tx_valid), 32'h0);
      chk({tag, "_txd"}, 32'(bus.tx_data), 32'h0);
      chk({tag, "_halt"}, 32'(bus.halted), 32'h0);
      chk({tag, "_txo"}, 32'(bus.tx_overflow), 32'h0);
      chk({tag, "_rxo"}, 32'(bus.rx_overflow), 32'h0);
   endtask

   initial begin
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] c0;
      int          drained;
      n_cmp = 0;
      n_err = 0;
      rst_n        = 1'b0;
      bus.cpu_a    = 32'h0002_0000;
      bus.cpu_wr   = 1'b0;
      bus.cpu_dout = 8'h00;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      rst_n = 1'b1;
      model_reset();

      // RAM round trip and unmapped read
      wr_cycle(32'h0000_0010, 8'hA5, 1'b0);
      rd_cycle(32'h0000_0010, 1'b0);
      chk("ram_rt", 32'(bus.cpu_din), 32'hA5);
      wr_cycle(32'h0002_0010, 8'h77, 1'b0);
      rd_cycle(32'h0002_0010, 1'b0);
      chk("unmapped_rd", 32'(bus.cpu_din), 32'h00);
      wr_cycle(32'hFFFC_0010, 8'h3C, 1'b0);
      rd_cycle(32'h0000_0010, 1'b0);
      chk("ram_hi_bits_ignored", 32'(bus.cpu_din), 32'h3C);

      // UART out: 'H','i',0x00 with receiver stalled, then drain
      wr_cycle(32'h0003_0000, 8'h48, 1'b0);
      wr_cycle(32'h0003_0000, 8'h69, 1'b0);
      wr_cycle(32'h0003_0000, 8'h00, 1'b0);
      chk("uart_head_h", 32'(bus.tx_data), 32'h48);
      rd_cycle(32'h0002_0000, 1'b1);
      chk("uart_head_i", 32'(bus.tx_data), 32'h69);
      rd_cycle(32'h0002_0000, 1'b1);
      chk("uart_empty", 32'(bus.tx_valid), 32'h0);

      // Back-pressure, full push+pop acceptance, overflow
      for (int i = 0; i < 16; i++) begin
         if (i == 11) chk("full_before_12", 32'(bus.io_buffer_full), 32'h0);
         wr_cycle(32'h0003_0000, 8'(8'h40 + i), 1'b0);
      end
      chk("full_after_16", 32'(bus.io_buffer_full), 32'h1);
      wr_cycle(32'h0003_0000, 8'h99, 1'b1);
      chk("push_pop_full_no_ovf", 32'(bus.tx_overflow), 32'h0);
      wr_cycle(32'h0003_0000, 8'hAA, 1'b0);
      chk("tx_ovf_set", 32'(bus.tx_overflow), 32'h1);
      drained = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.tx_valid) begin
            drained++;
            rd_cycle(32'h0002_0000, 1'b1);
         end
      end
      chk("tx_drain_len", 32'(drained), 32'd16);

      // UART in, including pop+push on empty
      do_cycle(32'h0002_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31);
      do_cycle(32'h0002_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h32);
      rd_cycle(32'h0003_0000, 1'b0);
      chk("rx_1", 32'(bus.cpu_din), 32'h31);
      rd_cycle(32'h0003_0000, 1'b0);
      chk("rx_2", 32'(bus.cpu_din), 32'h32);
      rd_cycle(32'h0003_0000, 1'b0);
      chk("rx_empty", 32'(bus.cpu_din), 32'h00);
      do_cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
      chk("rx_popempty_push", 32'(bus.cpu_din), 32'h00);
      rd_cycle(32'h0003_0000, 1'b0);
      chk("rx_retained", 32'(bus.cpu_din), 32'h55);

      // Cycle counter with snapshot
      c0 = m_cnt;
      rd_cycle(32'h0003_0004, 1'b0); b0 = bus.cpu_din;
      rd_cycle(32'h0003_0005, 1'b0); b1 = bus.cpu_din;
      rd_cycle(32'h0003_0006, 1'b0); b2 = bus.cpu_din;
      rd_cycle(32'h0003_0007, 1'b0); b3 = bus.cpu_din;
      chk("cnt_assembled", {b3, b2, b1, b0}, c0);

      // Halt, then asynchronous reset while transmission is pending
      chk("halt_pre", 32'(bus.halted), 32'h0);
      wr_cycle(32'h0003_0004, 8'h7F, 1'b0);
      chk("halt_set", 32'(bus.halted), 32'h1);
      chk("halt_zero_queued", 32'(bus.tx_valid), 32'h1);
      wr_cycle(32'h0003_0000, 8'h5A, 1'b0);
      rd_cycle(32'h0002_0000, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      c0 = m_cnt;
      rd_cycle(32'h0003_0004, 1'b0); b0 = bus.cpu_din;
      rd_cycle(32'h0003_0005, 1'b0); b1 = bus.cpu_din;
      chk("cnt_after_rst", {16'h0, b1, b0}, c0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [17:0] ia;
         logic [31:0] a;
         logic [7:0]  d;
         case ($urandom_range(0, 9))
            0, 1, 2: ia = 18'($urandom_range(0, 63));
            3:       ia = 18'h20000 + 18'($urandom_range(0, 255));
            4, 5:    ia = 18'h30000;
            6:       ia = 18'h30004;
            7:       ia = 18'h30005 + 18'($urandom_range(0, 2));
            8:       ia = 18'h30001 + 18'($urandom_range(0, 2));
            default: ia = 18'h30008;
         endcase
         a = {14'($urandom()), ia};
         d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
         do_cycle(a, 1'($urandom()), d, 1'($urandom()), 1'($urandom()), 8'($urandom()));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Target-side responder for the CPU's byte-wide memory bus: a synchronous byte RAM plus the memory-mapped I/O block at 0x30000/0x30004. It decodes each bus cycle, returns read data one cycle later, buffers UART output bytes in a TX queue drained by the UART transmitter, buffers UART input bytes in an RX queue, and drives the CPU's `io_buffer_full` back-pressure signal. It sits between the CPU top and the RAM/UART in the system wrapper.

## Interface
- `ADDR_WIDTH`, 17 — RAM byte-address width; RAM holds 2^ADDR_WIDTH bytes (128 KB).
- `TXQ_DEPTH`, 16 — TX queue entries; power of two, ≥ 4.
- `RXQ_DEPTH`, 16 — RX queue entries; power of two, ≥ 2.
- `FULL_MARGIN`, 4 — `io_buffer_full` asserts when TX occupancy ≥ `TXQ_DEPTH − FULL_MARGIN`; 1 ≤ `FULL_MARGIN` < `TXQ_DEPTH`.

- `clk_in` in 1 — single clock.
- `rst_in` in 1 — asynchronous, active-low reset.
- `cpu_a` in 32 — bus address; only bits [17:0] are decoded.
- `cpu_dout` in 8 — write data from CPU.
- `cpu_wr` in 1 — 1 = write, 0 = read; every cycle is a bus cycle.
- `cpu_din` out 8 — read data, registered.
- `io_buffer_full` out 1 — TX queue near full.
- `tx_data` out 8 — head of TX queue.
- `tx_valid` out 1 — TX queue non-empty.
- `tx_ready` in 1 — UART transmitter accepts `tx_data` when `tx_valid & tx_ready`.
- `rx_data` in 8 — received byte.
- `rx_valid` in 1 — push `rx_data` into the RX queue this cycle.
- `halted` out 1 — program-stop flag, sticky.
- `tx_overflow` out 1 — sticky; a TX push was dropped.
- `rx_overflow` out 1 — sticky; an RX push was dropped.

## Operation
- Decode: `a[17:16]==2'b11` → I/O. `a[17] == 0` → RAM at `a[ADDR_WIDTH−1:0]`. Otherwise (0x20000–0x2FFFF) → unmapped: writes ignored, reads return 0x00.
- RAM read: `cpu_din` ← RAM[a]. RAM write: byte stored at the clock edge. RAM contents are not reset.
- I/O address 0x30000:
  - Write pushes `cpu_dout` into the TX queue, except that 0x00 is ignored.
  - Read pops the RX queue head into `cpu_din`. If the RX queue is empty, the read returns 0x00 and the queue is unchanged.
  - Each read cycle at 0x30000 pops one byte; the CPU must not hold the address across cycles.
- I/O address 0x30004, cycle counter:
  - A 32-bit free-running counter starts at 0 at reset, increments every cycle and wraps at 2^32.
  - Reading 0x30004 returns live `count[7:0]` and latches `count[31:8]` into a snapshot.
  - Reading 0x30005/06/07 returns snapshot bytes 1/2/3.
- I/O address 0x30004, write: sets `halted` and pushes 0x00 into the TX queue regardless of `cpu_dout`. Once `halted` is set, further writes anywhere are still serviced.
- Other I/O addresses: reads return 0x00, writes are ignored.
- TX queue:
  - Push when full → byte dropped, `tx_overflow` set.
  - A push and a pop in the same cycle are both performed and occupancy is unchanged; this also holds when the queue is full, in which case the push is accepted.
- RX queue: same rules, with overflow reported on `rx_overflow`.
  - A CPU pop and an `rx_valid` push in the same cycle on an empty queue → read returns 0x00 and the pushed byte is retained.

## Timing
- Read latency is 1 cycle: address sampled at edge N, `cpu_din` valid after edge N (usable in cycle N+1). `cpu_din` holds its value on write cycles.
- Writes commit at the sampling edge.
- A RAM read from an address written in the immediately preceding cycle returns the new data.
- `io_buffer_full` is derived combinationally from the registered TX occupancy, so it updates the cycle after a push or pop.
- `tx_valid`/`tx_data` are combinational from the queue state. `tx_data` is stable while `tx_valid & !tx_ready`.
- Reset values: `cpu_din` = 0, `io_buffer_full` = 0, `tx_valid` = 0, `tx_data` = 0, `halted` = 0, both overflow flags = 0, counter = 0, snapshot = 0, both queues empty.
- Reset asserted mid-operation empties the queues immediately and asynchronously; the bus cycle in flight is discarded.

## Test plan
- RAM round trip: write 0xA5 to 0x00010, then read 0x00010 the next cycle → `cpu_din` = 0xA5 one cycle after the read. Read 0x20000 → 0x00.
- UART out: with `tx_ready` = 0, write 'H', 'i', 0x00 to 0x30000 → two entries queued. Then `tx_ready` = 1 → `tx_data` delivers 0x48, then 0x69, then `tx_valid` = 0.
- Back-pressure and overflow (`TXQ_DEPTH` = 16, `FULL_MARGIN` = 4, `tx_ready` = 0): after 12 pushes `io_buffer_full` = 1; the 17th push sets `tx_overflow`, and occupancy stays at 16.
- UART in: pulse `rx_valid` with 0x31 then 0x32, then read 0x30000 three times → 0x31, 0x32, 0x00.
- Counter: read 0x30004 in cycle C, then 0x30005–07 → the assembled value equals C relative to reset release; force the counter near 0xFFFFFFFF and confirm it wraps to 0.
- Halt: write 0x7F to 0x30004 → `halted` = 1 and a 0x00 byte is queued. Assert `rst_in` low mid-transfer → all outputs return to their reset values without waiting for a clock edge.
